instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
// - Producer side of the Instr interface: fetches 32-bit ARM instructions from instruction memory and presents them to controller/datapath.
// - Holds fetch PC; DEPTH-entry prefetch buffer decouples memory latency from the consumer.
// - Consumer redirects via PCSrc/BranchTarget; buffer is flushed and fetch restarts at target.
// PARAMETERS
// - DEPTH     2          prefetch buffer entries; power of 2, >=2
// - RESET_PC  32'h0      first fetch address after reset
// PORTS
// - clk          in   1   single clock, rising edge
// - reset        in   1   asynchronous, active-low reset (0 = in reset)
// - IAddr        out  32  instruction memory address, word aligned
// - IReq         out  1   memory request; IAddr held stable while IReq=1 and IAck=0
// - IAck         in   1   memory accepts request; IRData valid this cycle
// - IRData       in   32  instruction word returned with IAck
// - Instr        out  32  head-of-buffer instruction to controller/datapath
// - InstrPC      out  32  address of Instr
// - InstrValid   out  1   Instr/InstrPC valid
// - InstrTake    in   1   consumer accepts head; pop when InstrValid&InstrTake
// - PCSrc        in   1   redirect request (taken branch / PC write)
// - BranchTarget in   32  redirect address; bits [1:0] ignored, forced 0
// BEHAVIOUR
// - Reset (async assert): FetchPC=RESET_PC, buffer empty, InstrValid=0, IReq=0, IAddr=RESET_PC, Instr=0, InstrPC=0, state FETCH.
// - FSM states: FETCH, STALL, DISCARD.
//   - FETCH: IReq=1, IAddr=FetchPC. On IAck: push {FetchPC,IRData}, FetchPC+=4; to STALL if (count after push/pop)==DEPTH.
//   - STALL: IReq=0; back to FETCH the cycle after count<DEPTH.
//   - DISCARD: request outstanding at redirect time; IReq=1, IAddr=old address until IAck; returned data dropped; then FETCH at target.
// - Issue rule: at most one request outstanding; new request only if count<DEPTH (slot reserved).
// - Push and pop in the same cycle allowed; count unchanged; full buffer with pop this cycle keeps fetching.
// - Redirect (PCSrc=1), highest priority over push/pop that cycle:
//   - buffer flushed, InstrValid=0 next cycle; FetchPC<={BranchTarget[31:2],2'b00}.
//   - FETCH with IReq=1, IAck=0 -> DISCARD (target stored, stays in FetchPC).
//   - FETCH with IAck=1 same cycle -> returned word dropped, FETCH at target next cycle.
//   - STALL -> FETCH at target next cycle.
//   - PCSrc during DISCARD: target replaced, remains DISCARD.
// - Latency: IAck at cycle n -> InstrValid at n+1 if buffer was empty. PCSrc at n -> IReq/IAddr=target at n+1 -> with IAck at n+1, InstrValid at n+2.
// - Arithmetic: FetchPC+4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0 with no flag.
// - Buffer pointers log2(DEPTH) bits wrapping; count log2(DEPTH)+1 bits, never >DEPTH.
// - Instr/InstrPC combinational from buffer head; hold value while InstrValid=1 and no take/redirect.
// - Reset mid-request: outstanding request abandoned; memory ignores IReq=0.
// STRUCTURE
// - Shared package arm_fetch_pkg: state encodings (FETCH/STALL/DISCARD), INSTR_W=32, PC_INC=4.
// - Sub-module fetch_fifo: DEPTH x 64-bit ({pc,instr}) synchronous FIFO, push/pop/flush, count; flush overrides push/pop.
// - Top: FSM, FetchPC register, issue/discard logic.
// TESTING
// - Reset release, IAck tied 1, InstrTake=1 -> IAddr 0,4,8...; InstrValid from cycle 2; InstrPC follows IAddr one cycle later.
// - InstrTake=0, IAck=1, DEPTH=2 -> two pushes then IReq=0 (STALL); one take -> IReq=1 next cycle, IAddr=8.
// - IReq at 0x10, IAck delayed 3 cycles, PCSrc=1 target 0x100 in cycle 1 -> IAddr stays 0x10 until IAck, data dropped, then IAddr=0x100, InstrPC=0x100.
// - PCSrc=1 with target 0x203 in same cycle as IAck -> buffer empty next cycle, next IAddr=0x200, no stale Instr.
// - FetchPC at 0xFFFF_FFFC, IAck=1 -> next IAddr=0x0.
// - reset low mid-DISCARD -> outputs at reset values immediately; after release first IAddr=RESET_PC.

Source files
------------

// File: rtl/arm_fetch_pkg.sv
// Shared definitions for the ARM instruction fetch slice: fetch FSM
// encodings, instruction/PC widths and PC arithmetic helpers.
package arm_fetch_pkg;

   localparam int          INSTR_W = 32;
   localparam int          PC_W    = 32;
   localparam logic [31:0] PC_INC  = 32'd4;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      STALL   = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   // Sequential fetch address; wraps modulo 2^32 with no flag.
   function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
      return pc + PC_INC;
   endfunction

   // Redirect targets are word aligned by dropping the byte offset.
   function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] addr);
      return {addr[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO holding {pc, instr} pairs.
// Flush overrides push and pop. Storage is not reset; only pointers and
// count are, so an empty buffer never exposes stale entries as valid.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage; a flushed push is dropped.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one outstanding
// request at a time into instruction memory, and queues returned words
// in a prefetch buffer for the controller/datapath. A redirect flushes
// the buffer and restarts fetch at the branch target; a request already
// in flight at redirect time is completed and its data discarded.
module instr_fetch_unit
   import arm_fetch_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic               clk,
   input  logic               reset,
   output logic [PC_W-1:0]    IAddr,
   output logic               IReq,
   input  logic               IAck,
   input  logic [INSTR_W-1:0] IRData,
   output logic [INSTR_W-1:0] Instr,
   output logic [PC_W-1:0]    InstrPC,
   output logic               InstrValid,
   input  logic               InstrTake,
   input  logic               PCSrc,
   input  logic [PC_W-1:0]    BranchTarget
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t               state;
   logic [PC_W-1:0]            fetch_pc;
   logic [PC_W-1:0]            target;
   logic [PC_W-1:0]            seq_pc;
   logic [CW-1:0]              count;
   logic [CW-1:0]              count_nxt;
   logic                       room_nxt;
   logic                       do_push;
   logic                       do_pop;
   logic                       buf_empty;
   logic                       buf_full;
   logic [PC_W+INSTR_W-1:0]    buf_head;

   assign target  = pc_align(BranchTarget);
   assign seq_pc  = pc_next(fetch_pc);

   // Only a live FETCH handshake fills the buffer; redirects drop the word.
   assign do_push = (state == FETCH) & IReq & IAck & ~PCSrc;
   assign do_pop  = InstrValid & InstrTake & ~PCSrc;

   // Occupancy after this cycle decides whether a new slot may be reserved.
   assign count_nxt = PCSrc ? '0 : (count + CW'(do_push) - CW'(do_pop));
   assign room_nxt  = (count_nxt < CW'(DEPTH));

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (PC_W + INSTR_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (do_push),
      .wdata ({fetch_pc, IRData}),
      .pop   (do_pop),
      .flush (PCSrc),
      .head  (buf_head),
      .empty (buf_empty),
      .full  (buf_full),
      .count (count)
   );

   assign InstrValid = ~buf_empty;
   assign Instr      = InstrValid ? buf_head[INSTR_W-1:0]            : '0;
   assign InstrPC    = InstrValid ? buf_head[PC_W+INSTR_W-1:INSTR_W] : '0;

   // Fetch FSM with registered request/address; redirect has top priority.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= FETCH;
         IReq     <= 1'b0;
         IAddr    <= RESET_PC;
         fetch_pc <= RESET_PC;
      end else begin
         case (state)
            FETCH: begin
               if (PCSrc) begin
                  fetch_pc <= target;
                  if (IReq && !IAck) begin
                     // In-flight request must complete at its old address.
                     state <= DISCARD;
                  end else begin
                     IReq  <= 1'b1;
                     IAddr <= target;
                  end
               end else if (IReq) begin
                  if (IAck) begin
                     fetch_pc <= seq_pc;
                     if (room_nxt) begin
                        IAddr <= seq_pc;
                     end else begin
                        IReq  <= 1'b0;
                        state <= STALL;
                     end
                  end
               end else if (room_nxt) begin
                  IReq  <= 1'b1;
                  IAddr <= fetch_pc;
               end
            end
            STALL: begin
               if (PCSrc) begin
                  fetch_pc <= target;
                  state    <= FETCH;
                  IReq     <= 1'b1;
                  IAddr    <= target;
               end else if (room_nxt) begin
                  state <= FETCH;
                  IReq  <= 1'b1;
                  IAddr <= fetch_pc;
               end
            end
            DISCARD: begin
               // A newer redirect replaces the pending target.
               if (PCSrc) fetch_pc <= target;
               if (IAck) begin
                  state <= FETCH;
                  IReq  <= 1'b1;
                  IAddr <= PCSrc ? target : fetch_pc;
               end
            end
            default: begin
               state <= FETCH;
               IReq  <= 1'b0;
            end
         endcase
      end
   end

   logic unused_full;
   assign unused_full = buf_full;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by randomized
// handshake/redirect traffic, scored against the architectural program order.
module tb_instr_fetch_unit;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h0;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] IAddr;
   logic        IReq;
   logic        IAck;
   logic [31:0] IRData;
   logic [31:0] Instr;
   logic [31:0] InstrPC;
   logic        InstrValid;
   logic        InstrTake;
   logic        PCSrc;
   logic [31:0] BranchTarget;

   int checks = 0;
   int errors = 0;
   int n_takes = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] nxt_pc;

   always #5 clk = ~clk;

   // Instruction memory contents: a fixed scramble of the address.
   function automatic logic [31:0] memw(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   assign IRData = memw(IAddr);

   instr_fetch_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (RPC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .IAddr        (IAddr),
      .IReq         (IReq),
      .IAck         (IAck),
      .IRData       (IRData),
      .Instr        (Instr),
      .InstrPC      (InstrPC),
      .InstrValid   (InstrValid),
      .InstrTake    (InstrTake),
      .PCSrc        (PCSrc),
      .BranchTarget (BranchTarget)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
      end
   endtask

   // Keep the expected program-order stream a few entries ahead.
   task automatic refill();
      while (exp_q.size() < 4) begin
         exp_q.push_back({nxt_pc, memw(nxt_pc)});
         nxt_pc = nxt_pc + 32'd4;
      end
   endtask

   // Program order restarts at an aligned address (reset or redirect).
   task automatic restart(input logic [31:0] pc);
      exp_q.delete();
      nxt_pc = {pc[31:2], 2'b00};
      refill();
   endtask

   task automatic redirect(input logic [31:0] tgt);
      PCSrc        = 1'b1;
      BranchTarget = tgt;
      restart(tgt);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      refill();
   endtask

   // Monitor: scores every accepted instruction and the request protocol.
   initial begin
      logic        prev_ok;
      logic        prev_req;
      logic        prev_ack;
      logic        prev_src;
      logic [31:0] prev_addr;
      exp_t        e;
      prev_ok = 1'b0;
      prev_req = 1'b0;
      prev_ack = 1'b0;
      prev_src = 1'b0;
      prev_addr = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_ok = 1'b0;
         end else begin
            if (prev_ok && prev_req && !prev_ack) begin
               chk("req_held", {31'b0, IReq}, 32'd1);
               chk("addr_held", IAddr, prev_addr);
            end
            if (prev_ok && prev_src) chk("flush_empty", {31'b0, InstrValid}, 32'd0);
            if (InstrValid && InstrTake && !PCSrc) begin
               n_takes++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_underflow: got pc %h expected none", InstrPC);
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_pc", InstrPC, e.pc);
                  chk("sb_instr", Instr, e.ins);
               end
            end
            prev_ok   = 1'b1;
            prev_req  = IReq;
            prev_ack  = IAck;
            prev_src  = PCSrc;
            prev_addr = IAddr;
         end
      end
   end

   // Stimulus: directed scenarios, then randomized traffic.
   initial begin
      reset = 1'b0;
      IAck = 1'b0;
      InstrTake = 1'b0;
      PCSrc = 1'b0;
      BranchTarget = '0;
      restart(RPC);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ireq", {31'b0, IReq}, 32'd0);
      chk("rst_iaddr", IAddr, RPC);
      chk("rst_valid", {31'b0, InstrValid}, 32'd0);
      chk("rst_instr", Instr, 32'd0);
      chk("rst_instrpc", InstrPC, 32'd0);

      // Streaming with IAck and InstrTake held high.
      IAck = 1'b1;
      InstrTake = 1'b1;
      reset = 1'b1;
      step();
      chk("t1_req", {31'b0, IReq}, 32'd1);
      chk("t1_addr0", IAddr, 32'h0);
      chk("t1_valid0", {31'b0, InstrValid}, 32'd0);
      step();
      chk("t1_addr4", IAddr, 32'h4);
      chk("t1_valid1", {31'b0, InstrValid}, 32'd1);
      chk("t1_pc0", InstrPC, 32'h0);
      step();
      chk("t1_addr8", IAddr, 32'h8);
      chk("t1_pc4", InstrPC, 32'h4);

      // Buffer fills, fetch stalls, one take resumes fetch.
      reset = 1'b0;
      InstrTake = 1'b0;
      restart(RPC);
      step();
      reset = 1'b1;
      step();
      step();
      chk("t2_addr4", IAddr, 32'h4);
      step();
      chk("t2_stall_req", {31'b0, IReq}, 32'd0);
      chk("t2_stall_pc", InstrPC, 32'h0);
      step();
      chk("t2_stall_req2", {31'b0, IReq}, 32'd0);
      InstrTake = 1'b1;
      step();
      InstrTake = 1'b0;
      chk("t2_resume_req", {31'b0, IReq}, 32'd1);
      chk("t2_resume_addr", IAddr, 32'h8);
      chk("t2_resume_pc", InstrPC, 32'h4);

      // Redirect while a request is outstanding.
      reset = 1'b0;
      IAck = 1'b0;
      restart(RPC);
      step();
      reset = 1'b1;
      redirect(32'h10);
      step();
      chk("t3_addr10", IAddr, 32'h10);
      chk("t3_req", {31'b0, IReq}, 32'd1);
      redirect(32'h100);
      step();
      PCSrc = 1'b0;
      chk("t3_hold1", IAddr, 32'h10);
      step();
      chk("t3_hold2", IAddr, 32'h10);
      step();
      chk("t3_hold3", IAddr, 32'h10);
      IAck = 1'b1;
      step();
      chk("t3_tgt_addr", IAddr, 32'h100);
      chk("t3_dropped", {31'b0, InstrValid}, 32'd0);
      step();
      chk("t3_valid", {31'b0, InstrValid}, 32'd1);
      chk("t3_pc", InstrPC, 32'h100);
      chk("t3_instr", Instr, memw(32'h100));

      // Redirect in the same cycle as IAck, unaligned target.
      redirect(32'h203);
      step();
      PCSrc = 1'b0;
      chk("t4_empty", {31'b0, InstrValid}, 32'd0);
      chk("t4_no_stale", Instr, 32'd0);
      chk("t4_addr", IAddr, 32'h200);
      step();
      chk("t4_pc", InstrPC, 32'h200);

      // Fetch PC wrap at the top of the address space.
      redirect(32'hFFFF_FFFC);
      step();
      PCSrc = 1'b0;
      chk("t5_addr_top", IAddr, 32'hFFFF_FFFC);
      step();
      chk("t5_wrap", IAddr, 32'h0);
      chk("t5_pc_top", InstrPC, 32'hFFFF_FFFC);

      // Reset asserted while discarding.
      redirect(32'h80);
      step();
      chk("t6_addr80", IAddr, 32'h80);
      IAck = 1'b0;
      redirect(32'h300);
      step();
      PCSrc = 1'b0;
      chk("t6_discard_addr", IAddr, 32'h80);
      #1;
      reset = 1'b0;
      restart(RPC);
      #1;
      chk("t6_rst_req", {31'b0, IReq}, 32'd0);
      chk("t6_rst_addr", IAddr, RPC);
      chk("t6_rst_valid", {31'b0, InstrValid}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      IAck = 1'b1;
      step();
      chk("t6_first_addr", IAddr, RPC);
      chk("t6_first_req", {31'b0, IReq}, 32'd1);

      // Randomized handshakes, takes and redirects.
      n_takes = 0;
      for (int i = 0; i < 3000; i++) begin
         step();
         IAck      = ($urandom_range(0, 9) < 6);
         InstrTake = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 24) == 0) begin
            if ($urandom_range(0, 3) == 0) redirect(32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
            else                           redirect($urandom);
         end else begin
            PCSrc = 1'b0;
         end
      end
      PCSrc = 1'b0;
      InstrTake = 1'b0;
      step();
      step();
      chk("rand_progress", {31'b0, (n_takes >= 300)}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
